// File: rtl/riscv_pkg.sv
// Shared definitions for the data-memory responder slice.
//   dmem_state_t : responder FSM states (IDLE / WAIT / RESP)
//   DMEM_LANES   : number of byte lanes in a data word
//   lane_merge   : byte-lane write merge helper
package riscv_pkg;

  localparam int DMEM_LANES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  // Replace each byte of old_word whose lane enable is set with the same byte of new_word.
  function automatic logic [8*DMEM_LANES-1:0] lane_merge(
    input logic [8*DMEM_LANES-1:0] old_word,
    input logic [8*DMEM_LANES-1:0] new_word,
    input logic [DMEM_LANES-1:0]   lane_we
  );
    logic [8*DMEM_LANES-1:0] merged;
    merged = old_word;
    for (int i = 0; i < DMEM_LANES; i++) begin
      if (lane_we[i]) begin
        merged[8*i +: 8] = new_word[8*i +: 8];
      end else begin
        merged[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-addressed storage built from independent byte-wide lanes.
// Ports:
//   clk     : clock; lane writes occur on its rising edge
//   addr    : word index shared by read and write
//   lane_we : per-lane write enable
//   wdata   : write word (lane i takes wdata[8i+7:8i])
//   rdata   : combinational read of the word at addr (pre-write value)
// Contents are not reset.
module dmem_array
  import riscv_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic                    clk,
  input  logic [AW-1:0]           addr,
  input  logic [DMEM_LANES-1:0]   lane_we,
  input  logic [8*DMEM_LANES-1:0] wdata,
  output logic [8*DMEM_LANES-1:0] rdata
);

  for (genvar g = 0; g < DMEM_LANES; g++) begin : g_lane
    logic [7:0] lane_mem_r [DEPTH_WORDS];

    // Synchronous write of this lane's byte when its enable is set.
    always_ff @(posedge clk) begin
      if (lane_we[g]) begin
        lane_mem_r[addr] <= wdata[8*g +: 8];
      end
    end

    assign rdata[8*g +: 8] = lane_mem_r[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with a fixed number of wait states.
// A request is accepted in IDLE, held for WAIT_CYCLES cycles, then committed
// and answered with a one-cycle rvalid strobe.
// Ports:
//   clk    : clock
//   reset  : asynchronous active-high reset
//   req    : request valid
//   daddr  : byte address (word index = daddr[31:2])
//   we     : byte-lane write enables, 4'b0000 = read
//   dwdata : write data, lanes pre-replicated
//   ready  : high only in IDLE; req && ready accepts
//   rvalid : one-cycle response strobe
//   drdata : response word (post-commit value), 0 outside a valid in-range response
//   err    : word index out of range; only with rvalid
module dmem_responder
  import riscv_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [31:0] daddr,
  input  logic [3:0]  we,
  input  logic [31:0] dwdata,
  output logic        ready,
  output logic        rvalid,
  output logic [31:0] drdata,
  output logic        err
);

  localparam int          AW          = $clog2(DEPTH_WORDS);
  localparam logic [31:0] DEPTH_LIMIT = 32'(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_INIT   = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  dmem_state_t state_r;
  dmem_state_t state_next_s;
  logic [3:0]  cnt_r;

  // Captured transaction
  logic [29:0] idx_r;
  logic [3:0]  we_r;
  logic [31:0] wdata_r;

  // Registered outputs
  logic        ready_r;
  logic        rvalid_r;
  logic        err_r;
  logic [31:0] drdata_r;

  logic        accept_s;
  logic        go_resp_s;
  logic [29:0] txn_idx_s;
  logic [3:0]  txn_we_s;
  logic [31:0] txn_wdata_s;
  logic        in_range_s;
  logic [3:0]  arr_we_s;
  logic [31:0] arr_rdata_s;
  logic [31:0] merged_s;
  logic        unused_daddr_s;

  assign unused_daddr_s = ^daddr[1:0];

  assign accept_s = (state_r == IDLE) && req;

  // With zero wait states the commit happens on the accept edge itself, before
  // the capture registers hold anything, so the live inputs feed the commit path
  // while in IDLE and the captured copy is used afterwards.
  // Transaction source select: live inputs in IDLE, captured copy otherwise.
  always_comb begin
    txn_idx_s   = idx_r;
    txn_we_s    = we_r;
    txn_wdata_s = wdata_r;
    if (state_r == IDLE) begin
      txn_idx_s   = daddr[31:2];
      txn_we_s    = we;
      txn_wdata_s = dwdata;
    end else begin
      txn_idx_s   = idx_r;
      txn_we_s    = we_r;
      txn_wdata_s = wdata_r;
    end
  end

  assign in_range_s = ({2'b00, txn_idx_s} < DEPTH_LIMIT);

  // Next-state decode for the IDLE / WAIT / RESP sequence.
  always_comb begin
    state_next_s = IDLE;
    case (state_r)
      IDLE: begin
        if (req) begin
          if (WAIT_CYCLES == 0) begin
            state_next_s = RESP;
          end else begin
            state_next_s = WAIT;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      WAIT: begin
        if (cnt_r == 4'd0) begin
          state_next_s = RESP;
        end else begin
          state_next_s = WAIT;
        end
      end
      RESP:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // The edge entering RESP is the commit edge.
  assign go_resp_s = (state_next_s == RESP);

  // Out-of-range requests never reach the array.
  // Array write enables: only on the commit edge and only for in-range indices.
  always_comb begin
    arr_we_s = 4'b0000;
    if (go_resp_s && in_range_s) begin
      arr_we_s = txn_we_s;
    end else begin
      arr_we_s = 4'b0000;
    end
  end

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk     (clk),
    .addr    (txn_idx_s[AW-1:0]),
    .lane_we (arr_we_s),
    .wdata   (txn_wdata_s),
    .rdata   (arr_rdata_s)
  );

  // Response word equals the post-commit contents: old word with the written lanes replaced.
  assign merged_s = lane_merge(arr_rdata_s, txn_wdata_s, txn_we_s);

  // FSM state and wait counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_next_s;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            cnt_r <= WAIT_INIT;
          end else begin
            cnt_r <= 4'd0;
          end
        end
        WAIT: begin
          if (cnt_r != 4'd0) begin
            cnt_r <= cnt_r - 4'd1;
          end else begin
            cnt_r <= 4'd0;
          end
        end
        default: cnt_r <= 4'd0;
      endcase
    end
  end

  // Capture the request on the accept edge; later input changes are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_r   <= 30'd0;
      we_r    <= 4'd0;
      wdata_r <= 32'd0;
    end else if (accept_s) begin
      idx_r   <= daddr[31:2];
      we_r    <= we;
      wdata_r <= dwdata;
    end else begin
      idx_r   <= idx_r;
      we_r    <= we_r;
      wdata_r <= wdata_r;
    end
  end

  // Registered handshake and response outputs; all response fields are zero outside RESP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_r  <= 1'b1;
      rvalid_r <= 1'b0;
      err_r    <= 1'b0;
      drdata_r <= 32'd0;
    end else begin
      ready_r  <= (state_next_s == IDLE);
      rvalid_r <= go_resp_s;
      err_r    <= go_resp_s && !in_range_s;
      if (go_resp_s && in_range_s) begin
        drdata_r <= merged_s;
      end else begin
        drdata_r <= 32'd0;
      end
    end
  end

  assign ready  = ready_r;
  assign rvalid = rvalid_r;
  assign err    = err_r;
  assign drdata = drdata_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: DUT A (default parameters) for wait-state timing, merge,
// range and reset-abort behaviour; DUT B (WAIT_CYCLES=0) for back-to-back accepts.
module tb_dmem_responder;

  localparam int DEPTH_A = 1024;
  localparam int WAIT_A  = 2;
  localparam int DEPTH_B = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_a, req_b;
  logic [31:0] daddr_a, daddr_b, dwdata_a, dwdata_b;
  logic [3:0]  we_a, we_b;
  logic        ready_a, rvalid_a, err_a, ready_b, rvalid_b, err_b;
  logic [31:0] drdata_a, drdata_b;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference memory contents of DUT A, keyed by word index (only words written so far).
  logic [31:0] model [int unsigned];

  dmem_responder #(.DEPTH_WORDS(DEPTH_A), .WAIT_CYCLES(WAIT_A)) dut_a (
    .clk(clk), .reset(reset), .req(req_a), .daddr(daddr_a), .we(we_a),
    .dwdata(dwdata_a), .ready(ready_a), .rvalid(rvalid_a), .drdata(drdata_a), .err(err_a)
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH_B), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .reset(reset), .req(req_b), .daddr(daddr_b), .we(we_b),
    .dwdata(dwdata_b), .ready(ready_b), .rvalid(rvalid_b), .drdata(drdata_b), .err(err_b)
  );

  function automatic logic [31:0] byte_update(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] wen);
    logic [31:0] m;
    m = {{8{wen[3]}}, {8{wen[2]}}, {8{wen[1]}}, {8{wen[0]}}};
    return (old_w & ~m) | (new_w & m);
  endfunction

  // One full transaction on DUT A with timing, response and idle-output checks.
  task automatic drive_txn(input logic [31:0] addr, input logic [3:0] wen,
                           input logic [31:0] wd, input string tag);
    int unsigned idx;
    logic        exp_err;
    logic [31:0] exp_data;
    int          lat;
    int          early_ready;
    logic        got_err;
    logic [31:0] got_data;
    logic        got_ready;
    idx = addr >> 2;
    if (idx >= DEPTH_A) begin
      exp_err  = 1'b1;
      exp_data = 32'h0;
    end else begin
      exp_err  = 1'b0;
      exp_data = byte_update(model.exists(idx) ? model[idx] : 32'h0, wd, wen);
      if (wen != 4'b0000) model[idx] = exp_data;
    end

    @(negedge clk);
    n_cmp++;
    if (ready_a !== 1'b1) begin
      n_mis++;
      $display("FAIL %s idle_ready: got %b expected 1", tag, ready_a);
    end
    req_a = 1'b1; daddr_a = addr; we_a = wen; dwdata_a = wd;
    @(posedge clk); #1;
    // Scramble inputs after accept: the transaction must use captured values.
    req_a = 1'b0; daddr_a = $urandom; we_a = 4'($urandom_range(0, 15)); dwdata_a = $urandom;

    lat = 0; early_ready = 0; got_err = 1'b0; got_data = 32'h0; got_ready = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      if (k > 1) begin
        @(posedge clk); #1;
      end
      if (rvalid_a === 1'b1) begin
        lat = k; got_err = err_a; got_data = drdata_a; got_ready = ready_a;
        break;
      end
      if (ready_a !== 1'b0) early_ready++;
    end

    n_cmp++;
    if (lat != WAIT_A + 1) begin
      n_mis++;
      $display("FAIL %s latency: got %0d expected %0d (0 = no rvalid within budget)", tag, lat, WAIT_A + 1);
    end
    n_cmp++;
    if (early_ready != 0 || got_ready !== 1'b0) begin
      n_mis++;
      $display("FAIL %s ready_busy: ready high in %0d wait cycles, %b in RESP, expected 0", tag, early_ready, got_ready);
    end
    n_cmp++;
    if (got_err !== exp_err) begin
      n_mis++;
      $display("FAIL %s err: got %b expected %b", tag, got_err, exp_err);
    end
    n_cmp++;
    if (got_data !== exp_data) begin
      n_mis++;
      $display("FAIL %s drdata: got %h expected %h", tag, got_data, exp_data);
    end

    @(posedge clk); #1;
    n_cmp++;
    if (rvalid_a !== 1'b0 || err_a !== 1'b0 || drdata_a !== 32'h0 || ready_a !== 1'b1) begin
      n_mis++;
      $display("FAIL %s after_resp: rvalid=%b err=%b drdata=%h ready=%b expected 0 0 00000000 1",
               tag, rvalid_a, err_a, drdata_a, ready_a);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_a = 1'b0; daddr_a = 32'h0; we_a = 4'h0; dwdata_a = 32'h0;
    req_b = 1'b0; daddr_b = 32'h0; we_b = 4'h0; dwdata_b = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (ready_a !== 1'b1 || rvalid_a !== 1'b0 || err_a !== 1'b0 || drdata_a !== 32'h0) begin
      n_mis++;
      $display("FAIL reset_a: ready=%b rvalid=%b err=%b drdata=%h expected 1 0 0 00000000",
               ready_a, rvalid_a, err_a, drdata_a);
    end
    n_cmp++;
    if (ready_b !== 1'b1 || rvalid_b !== 1'b0 || err_b !== 1'b0 || drdata_b !== 32'h0) begin
      n_mis++;
      $display("FAIL reset_b: ready=%b rvalid=%b err=%b drdata=%h expected 1 0 0 00000000",
               ready_b, rvalid_b, err_b, drdata_b);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic_write();
    drive_txn(32'h0000_0010, 4'b1111, 32'hDEAD_BEEF, "basic_wr");
  endtask

  task automatic test_byte_merge();
    drive_txn(32'h0000_0010, 4'b0100, 32'h5555_5555, "merge_wr");
    drive_txn(32'h0000_0010, 4'b0000, 32'h0, "merge_rd");
    n_cmp++;
    if (model[4] !== 32'hDE55_BEEF) begin
      n_mis++;
      $display("FAIL merge_model: got %h expected de55beef", model[4]);
    end
  endtask

  task automatic test_init_words();
    for (int i = 0; i < 16; i++) drive_txn(32'(i * 4), 4'b1111, $urandom, "init");
    drive_txn(32'h0000_0FFC, 4'b1111, $urandom, "top_word_wr");
    drive_txn(32'h0000_0FFE, 4'b0000, 32'h0, "top_word_rd");
  endtask

  task automatic test_out_of_range();
    drive_txn(32'(DEPTH_A * 4), 4'b0000, 32'h0, "oor_rd");
    drive_txn(32'(DEPTH_A * 4), 4'b1111, 32'h1234_5678, "oor_wr");
    drive_txn(32'hFFFF_FFFF, 4'b1010, $urandom, "oor_max");
    for (int i = 0; i < 16; i++) drive_txn(32'(i * 4), 4'b0000, 32'h0, "oor_check");
    drive_txn(32'h0000_0FFC, 4'b0000, 32'h0, "oor_check_top");
  endtask

  task automatic test_random();
    logic [31:0] addr;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 7) == 0)
        addr = 32'(((DEPTH_A * $urandom_range(1, 3) + $urandom_range(0, 15)) << 2) | $urandom_range(0, 3));
      else
        addr = 32'(($urandom_range(0, 15) << 2) | $urandom_range(0, 3));
      drive_txn(addr, 4'($urandom_range(0, 15)), $urandom, "random");
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] wd_hist [12];
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      req_b = 1'b1; we_b = 4'b1111;
      daddr_b = 32'(((i / 2) % DEPTH_B) * 4);
      dwdata_b = 32'hA500_0000 | 32'(i);
      wd_hist[i] = dwdata_b;
      @(posedge clk); #1;
      n_cmp++;
      if ((i % 2) == 0) begin
        if (rvalid_b !== 1'b1 || ready_b !== 1'b0 || drdata_b !== wd_hist[i] || err_b !== 1'b0) begin
          n_mis++;
          $display("FAIL b2b_resp[%0d]: rvalid=%b ready=%b drdata=%h err=%b expected 1 0 %h 0",
                   i, rvalid_b, ready_b, drdata_b, err_b, wd_hist[i]);
        end
      end else begin
        if (rvalid_b !== 1'b0 || ready_b !== 1'b1 || drdata_b !== 32'h0) begin
          n_mis++;
          $display("FAIL b2b_idle[%0d]: rvalid=%b ready=%b drdata=%h expected 0 1 00000000",
                   i, rvalid_b, ready_b, drdata_b);
        end
      end
    end
    @(negedge clk);
    req_b = 1'b1; we_b = 4'b0000; daddr_b = 32'h0000_0014; dwdata_b = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    req_b = 1'b0;
    n_cmp++;
    if (rvalid_b !== 1'b1 || drdata_b !== wd_hist[10]) begin
      n_mis++;
      $display("FAIL b2b_readback: rvalid=%b drdata=%h expected 1 %h", rvalid_b, drdata_b, wd_hist[10]);
    end
  endtask

  task automatic test_reset_abort();
    int seen;
    @(negedge clk);
    req_a = 1'b1; daddr_a = 32'h0000_0020; we_a = 4'b1111; dwdata_a = ~model[8];
    @(posedge clk); #1;
    req_a = 1'b0;
    n_cmp++;
    if (ready_a !== 1'b0 || rvalid_a !== 1'b0) begin
      n_mis++;
      $display("FAIL abort_wait: ready=%b rvalid=%b expected 0 0", ready_a, rvalid_a);
    end
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if (ready_a !== 1'b1 || rvalid_a !== 1'b0 || err_a !== 1'b0 || drdata_a !== 32'h0) begin
      n_mis++;
      $display("FAIL abort_async: ready=%b rvalid=%b err=%b drdata=%h expected 1 0 0 00000000",
               ready_a, rvalid_a, err_a, drdata_a);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (rvalid_a !== 1'b0) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_mis++;
      $display("FAIL abort_no_resp: rvalid seen %0d times expected 0", seen);
    end
    drive_txn(32'h0000_0020, 4'b0000, 32'h0, "abort_readback");
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_byte_merge();
    test_init_words();
    test_out_of_range();
    test_random();
    test_back_to_back();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
